dcache_wb_direct: RTL and testbench

//  Parametrised direct-mapped write-back data cache between the CPU data port
//  (addr/data/mem_write/mem_access_valid) and word-wide main memory.

---
 rtl/dcache_wb_direct_if.sv | 26 ++
 rtl/dcache_wb_direct.sv | 98 +++++++++
 tb/tb_dcache_wb_direct.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_wb_direct_if.sv
// dcache_wb_direct_if: CPU data port and word-wide memory port of the data cache.
// The cache is the slave side; the CPU/memory environment is the master side.
interface dcache_wb_direct_if #(parameter int DATA_W = 32);
    logic              cpu_valid;
    logic              cpu_we;
    logic [31:0]       cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;
    logic              mem_req;
    logic              mem_we;
    logic [31:0]       mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport slave (
        input  cpu_valid, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
        output cpu_rdata, cpu_stall, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output cpu_valid, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_ack,
        input  cpu_rdata, cpu_stall, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dcache_wb_direct.sv
// dcache_wb_direct: direct-mapped write-back data cache; hits finish in the request
// cycle, misses stall while the victim line is written back and the new line refilled.
module dcache_wb_direct #(
    parameter int DATA_W         = 32,
    parameter int LINES          = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input logic               clk,
    input logic               rst,
    dcache_wb_direct_if.slave bus
);
    localparam int OFF_W = $clog2(WORDS_PER_LINE);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 30 - OFF_W - IDX_W;
    localparam int LA_W  = TAG_W + IDX_W;

    typedef enum logic [1:0] {IDLE, WB, REFILL} state_t;

    state_t            r_state, w_state_n;
    logic [OFF_W-1:0]  r_cnt, w_cnt_n;
    logic [LA_W-1:0]   r_line;
    logic [LINES-1:0]  r_valid, r_dirty;
    logic [TAG_W-1:0]  r_tag [LINES];
    logic [DATA_W-1:0] r_data [LINES][WORDS_PER_LINE];
    logic [DATA_W-1:0] r_rdata;

    logic              w_idle, w_hit, w_miss, w_load_hit, w_store_hit, w_ack, w_last, w_unused;
    logic [LA_W-1:0]   w_line;
    logic [TAG_W-1:0]  w_tag;
    logic [IDX_W-1:0]  w_idx;
    logic [OFF_W-1:0]  w_off;
    logic [DATA_W-1:0] w_word;

    // In IDLE the live CPU address selects the line; during a miss the latched one does.
    assign w_idle      = r_state == IDLE;
    assign w_line      = w_idle ? bus.cpu_addr[31:2+OFF_W] : r_line;
    assign w_tag       = w_line[LA_W-1:IDX_W];
    assign w_idx       = w_line[IDX_W-1:0];
    assign w_off       = w_idle ? bus.cpu_addr[OFF_W+1:2] : r_cnt;
    assign w_word      = r_data[w_idx][w_off];
    assign w_hit       = r_valid[w_idx] && r_tag[w_idx] == w_tag;
    assign w_miss      = w_idle && bus.cpu_valid && !w_hit;
    assign w_load_hit  = w_idle && bus.cpu_valid && w_hit && !bus.cpu_we;
    assign w_store_hit = w_idle && bus.cpu_valid && w_hit && bus.cpu_we;
    assign w_ack       = !w_idle && bus.mem_ack;
    assign w_last      = r_cnt == OFF_W'(WORDS_PER_LINE - 1);
    assign w_unused    = ^bus.cpu_addr[1:0];

    assign bus.cpu_stall = w_idle ? w_miss : 1'b1;
    assign bus.cpu_rdata = w_load_hit ? w_word : r_rdata;
    assign bus.mem_req   = !w_idle;
    assign bus.mem_we    = r_state == WB;
    assign bus.mem_addr  = w_idle ? '0 : {r_state == WB ? r_tag[w_idx] : w_tag, w_idx, r_cnt, 2'b00};
    assign bus.mem_wdata = r_state == WB ? w_word : '0;

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = w_ack ? r_cnt + OFF_W'(1) : r_cnt;
        if (w_miss)
            w_state_n = (r_valid[w_idx] && r_dirty[w_idx]) ? WB : REFILL;
        if (w_ack && w_last)
            w_state_n = r_state == WB ? REFILL : IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_valid <= '0;
            r_dirty <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            if (w_load_hit)
                r_rdata <= w_word;
            if (w_store_hit)
                r_dirty[w_idx] <= 1'b1;
            if (w_ack && w_last) begin
                r_dirty[w_idx] <= 1'b0;
                if (r_state == REFILL)
                    r_valid[w_idx] <= 1'b1;
            end
        end
    end

    // Line storage carries no reset: its contents are meaningless while the line is invalid.
    always_ff @(posedge clk) begin
        if (w_miss)
            r_line <= bus.cpu_addr[31:2+OFF_W];
        if (w_store_hit)
            r_data[w_idx][w_off] <= bus.cpu_wdata;
        if (w_ack && r_state == REFILL)
            r_data[w_idx][r_cnt] <= bus.mem_rdata;
        if (w_ack && w_last && r_state == REFILL)
            r_tag[w_idx] <= w_tag;
    end
endmodule

// File: tb/tb_dcache_wb_direct.sv
// tb_dcache_wb_direct: vector table, hand-written reset/spurious-ack sequences and a
// randomized run checked against a line-level cache model and a flat memory image.
module tb_dcache_wb_direct;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dcache_wb_direct_if #(.DATA_W(32)) bus();
    dcache_wb_direct #(.DATA_W(32), .LINES(16), .WORDS_PER_LINE(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {logic we; logic [31:0] addr; logic [31:0] data;} txn_t;
    typedef struct {logic we; logic [31:0] addr; logic [31:0] wdata; int wt; logic [31:0] exp_rd; int exp_st; logic chk_rd;} vec_t;

    int n_pass = 0;
    int n_tot  = 0;
    int wait_n = 0;
    int wcnt   = 0;
    logic spur = 1'b0;
    logic [31:0] mem [4096];
    bit   wr_ok [4096];
    txn_t log_q[$];
    txn_t mon_t;

    // Reference model: line bookkeeping plus the value the CPU must observe per word.
    bit          m_valid [16];
    bit          m_dirty [16];
    logic [23:0] m_tag   [16];
    logic [31:0] gold [int unsigned];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    endtask

    function automatic logic [31:0] gval(input logic [31:0] a);
        int unsigned w = int'(a[31:2]);
        if (gold.exists(w)) return gold[w];
        return wr_ok[a[13:2]] ? mem[a[13:2]] : (a & 32'h3FFC) + 32'hA000;
    endfunction

    task automatic mdl_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        gold.delete();
    endtask

    // Memory: default word at byte address a is a+0xA000; writebacks overwrite it.
    assign bus.mem_ack   = (bus.mem_req && wcnt >= wait_n) || spur;
    assign bus.mem_rdata = wr_ok[bus.mem_addr[13:2]] ? mem[bus.mem_addr[13:2]]
                                                     : {18'd0, bus.mem_addr[13:2], 2'b00} + 32'hA000;

    always @(posedge clk) begin
        wcnt <= (rst || !bus.mem_req || bus.mem_ack) ? 0 : wcnt + 1;
        if (bus.mem_req && bus.mem_ack && !rst) begin
            mon_t.we   = bus.mem_we;
            mon_t.addr = bus.mem_addr;
            mon_t.data = bus.mem_we ? bus.mem_wdata : bus.mem_rdata;
            log_q.push_back(mon_t);
            if (bus.mem_we) begin
                mem[bus.mem_addr[13:2]]   <= bus.mem_wdata;
                wr_ok[bus.mem_addr[13:2]] <= 1'b1;
            end
        end
    end

    // A request not yet acknowledged must keep its request, direction, address and data.
    logic p_req = 1'b0, p_ack = 1'b0, p_rst = 1'b1, p_we = 1'b0;
    logic [31:0] p_addr = '0, p_wd = '0;
    always @(negedge clk) begin
        if (p_req && !p_ack && !p_rst) begin
            chk("hold_req_addr", {bus.mem_req, bus.mem_addr}, {1'b1, p_addr});
            chk("hold_we_wdata", {bus.mem_we, bus.mem_wdata}, {p_we, p_wd});
        end
        p_req  <= bus.mem_req;
        p_ack  <= bus.mem_ack;
        p_rst  <= rst;
        p_we   <= bus.mem_we;
        p_addr <= bus.mem_addr;
        p_wd   <= bus.mem_wdata;
    end

    // Called at posedge+1; returns at posedge+1 after the access completes.
    task automatic access(input logic we, input logic [31:0] a, input logic [31:0] wd, input int wt,
                          output logic [31:0] rd, output int st, output logic [31:0] e_rd, output int e_st);
        txn_t exq[$];
        txn_t t;
        int idx = int'(a[7:4]);
        logic [23:0] tg = a[31:8];
        bit dirty;
        e_rd = gval(a);
        e_st = 0;
        if (!(m_valid[idx] && m_tag[idx] == tg)) begin
            dirty = m_valid[idx] && m_dirty[idx];
            if (dirty)
                for (int k = 0; k < 4; k++) begin
                    t.we = 1'b1;
                    t.addr = {m_tag[idx], a[7:4], 2'(k), 2'b00};
                    t.data = gval(t.addr);
                    exq.push_back(t);
                end
            for (int k = 0; k < 4; k++) begin
                t.we = 1'b0;
                t.addr = {tg, a[7:4], 2'(k), 2'b00};
                t.data = '0;
                exq.push_back(t);
            end
            e_st = (dirty ? 8 : 4) * (wt + 1) + 1;
            m_tag[idx] = tg;
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
        end
        if (we) begin
            gold[int'(a[31:2])] = wd;
            m_dirty[idx] = 1'b1;
        end
        wait_n = wt;
        log_q.delete();
        bus.cpu_valid = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = a;
        bus.cpu_wdata = wd;
        st = 0;
        forever begin
            @(negedge clk);
            if (!bus.cpu_stall) break;
            st++;
            if (st > 200) begin
                chk("stall_timeout", 64'(st), 64'd0);
                break;
            end
            @(posedge clk); #1;
        end
        rd = bus.cpu_rdata;
        @(posedge clk); #1;
        bus.cpu_valid = 1'b0;
        chk("txn_count", 64'(log_q.size()), 64'(exq.size()));
        for (int i = 0; i < exq.size() && i < log_q.size(); i++) begin
            chk("txn_we_addr", {log_q[i].we, log_q[i].addr}, {exq[i].we, exq[i].addr});
            if (exq[i].we) chk("wb_data", log_q[i].data, exq[i].data);
        end
    endtask

    initial begin
        vec_t vt [9];
        logic [31:0] rd, e_rd, last_rd;
        int st, e_st, guard;
        logic we, have_ld;
        logic [31:0] a;
        vt[0] = '{1'b0, 32'h100, 32'h0,    0, 32'hA100, 5,  1'b1};
        vt[1] = '{1'b0, 32'h104, 32'h0,    0, 32'hA104, 0,  1'b1};
        vt[2] = '{1'b1, 32'h108, 32'hDEAD, 0, 32'h0,    0,  1'b0};
        vt[3] = '{1'b0, 32'h508, 32'h0,    0, 32'hA508, 9,  1'b1};
        vt[4] = '{1'b0, 32'h10C, 32'h0,    3, 32'hA10C, 17, 1'b1};
        vt[5] = '{1'b0, 32'h108, 32'h0,    0, 32'hDEAD, 0,  1'b1};
        vt[6] = '{1'b1, 32'h504, 32'h55,   1, 32'h0,    9,  1'b0};
        vt[7] = '{1'b0, 32'h504, 32'h0,    0, 32'h55,   0,  1'b1};
        vt[8] = '{1'b0, 32'h10C, 32'h0,    0, 32'hA10C, 9,  1'b1};
        bus.cpu_valid = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        mdl_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", bus.cpu_stall, 0);
        chk("rst_req",   bus.mem_req,   0);
        chk("rst_we",    bus.mem_we,    0);
        chk("rst_addr",  bus.mem_addr,  0);
        chk("rst_wdata", bus.mem_wdata, 0);
        chk("rst_rdata", bus.cpu_rdata, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            access(vt[i].we, vt[i].addr, vt[i].wdata, vt[i].wt, rd, st, e_rd, e_st);
            if (vt[i].chk_rd) chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
            chk($sformatf("vec%0d_stall", i), 64'(st), 64'(vt[i].exp_st));
        end
        chk("wb_word_0x108", mem[12'h042], 32'hDEAD);

        // Reset while the second refill word is outstanding.
        wait_n = 2;
        log_q.delete();
        bus.cpu_valid = 1'b1;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = 32'h2030;
        guard = 0;
        while (log_q.size() < 1 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("rst_mid_first_ack", 64'(log_q.size()), 64'd1);
        rst = 1'b1;
        bus.cpu_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_req", bus.mem_req, 0);
        chk("rst_mid_stall", bus.cpu_stall, 0);
        chk("rst_mid_acks", 64'(log_q.size()), 64'd1);
        mdl_reset();
        @(posedge clk); #1;
        access(1'b0, 32'h2030, 32'h0, 2, rd, st, e_rd, e_st);
        chk("reload_rdata", rd, 32'hC030);
        chk("reload_stall", 64'(st), 64'd13);

        // Spurious ack in IDLE, then a store miss whose dirty line is later evicted.
        spur = 1'b1;
        @(negedge clk);
        chk("spur_req", bus.mem_req, 0);
        @(posedge clk); #1;
        spur = 1'b0;
        @(negedge clk);
        chk("spur_after_req", bus.mem_req, 0);
        chk("spur_after_stall", bus.cpu_stall, 0);
        @(posedge clk); #1;
        access(1'b0, 32'h2034, 32'h0, 0, rd, st, e_rd, e_st);
        chk("spur_hit_rdata", rd, 32'hC034);
        chk("spur_hit_stall", 64'(st), 64'd0);
        access(1'b1, 32'h3034, 32'h1234, 1, rd, st, e_rd, e_st);
        chk("store_miss_stall", 64'(st), 64'd9);
        access(1'b0, 32'h3034, 32'h0, 0, rd, st, e_rd, e_st);
        chk("store_miss_rdata", rd, 32'h1234);
        chk("store_miss_hit", 64'(st), 64'd0);
        access(1'b0, 32'h2038, 32'h0, 0, rd, st, e_rd, e_st);
        chk("evict_stall", 64'(st), 64'd9);
        chk("evict_rdata", rd, 32'hC038);
        chk("evict_mem", mem[12'hC0D], 32'h1234);

        // Randomized traffic over 4 tags per line to mix hits, clean and dirty misses.
        have_ld = 1'b0;
        last_rd = '0;
        for (int i = 0; i < 300; i++) begin
            we = 1'($urandom_range(0, 1));
            a  = {22'd0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 2'b00};
            access(we, a, $urandom, $urandom_range(0, 2), rd, st, e_rd, e_st);
            if (!we) begin
                chk("rand_rdata", rd, e_rd);
                last_rd = e_rd;
                have_ld = 1'b1;
            end
            chk("rand_stall", 64'(st), 64'(e_st));
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                if (have_ld) chk("rdata_hold", bus.cpu_rdata, last_rd);
                @(posedge clk); #1;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
